guess_index_encoder: RTL and testbench

//  Inverse of the guess generator: converts a matched 128-bit ASCII guess back to its linear keyspace index.

---
 rtl/guess_index_encoder_pkg.sv | 36 +++
 rtl/guess_index_encoder_if.sv | 27 ++
 rtl/charset_reverse_rom.sv | 72 +++++++
 rtl/guess_index_encoder.sv | 131 +++++++++++++
 tb/tb_guess_index_encoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/guess_index_encoder_pkg.sv
// Shared charset codes, size table and FSM state type for the
// guess index encoder and guess generator.
package guess_index_encoder_pkg;

  localparam int DEF_GUESS_BYTES = 16;
  localparam int DEF_IDX_W = 128;

  localparam logic [2:0] CS_LOWER = 3'd0;
  localparam logic [2:0] CS_UPPER = 3'd1;
  localparam logic [2:0] CS_ALPHA = 3'd2;
  localparam logic [2:0] CS_ALNUM = 3'd3;
  localparam logic [2:0] CS_PRINT = 3'd4;
  localparam logic [2:0] CS_FULL  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  function automatic logic [8:0] cs_size(
    input logic [2:0] cs
  );
    unique case (cs)
      CS_LOWER: cs_size = 9'd26;
      CS_UPPER: cs_size = 9'd26;
      CS_ALPHA: cs_size = 9'd52;
      CS_ALNUM: cs_size = 9'd62;
      CS_PRINT: cs_size = 9'd94;
      CS_FULL:  cs_size = 9'd256;
      default:  cs_size = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/guess_index_encoder_if.sv
// Request/result bundle of the guess index encoder.
// master: start/charset/guesslen/guess out; slave: busy/done/err/index out.
interface guess_index_encoder_if
  import guess_index_encoder_pkg::*;
#(
  parameter int GUESS_BYTES = DEF_GUESS_BYTES,
  parameter int IDX_W = DEF_IDX_W
);
  logic                     start;
  logic [2:0]               charset;
  logic [4:0]               guesslen;
  logic [8*GUESS_BYTES-1:0] guess;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [IDX_W-1:0]         index;

  modport master (
    output start, charset, guesslen, guess,
    input  busy, done, err, index
  );

  modport slave (
    input  start, charset, guesslen, guess,
    output busy, done, err, index
  );
endinterface

// File: rtl/charset_reverse_rom.sv
// Character -> digit lookup for one charset, registered (1 cycle).
// Ports: clk, charset, ch in; digit, valid out.
module charset_reverse_rom
  import guess_index_encoder_pkg::*;
(
  input  logic       clk,
  input  logic [2:0] charset,
  input  logic [7:0] ch,
  output logic [7:0] digit,
  output logic       valid
);

  logic       is_lo;
  logic       is_up;
  logic       is_num;
  logic       is_prt;
  logic [7:0] d_c;
  logic       v_c;

  assign is_lo  = (ch >= 8'h61) && (ch <= 8'h7a);
  assign is_up  = (ch >= 8'h41) && (ch <= 8'h5a);
  assign is_num = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_prt = (ch >= 8'h21) && (ch <= 8'h7e);

  always_comb begin
    d_c = 8'h00;
    v_c = 1'b0;
    unique case (charset)
      CS_LOWER: begin
        v_c = is_lo;
        d_c = ch - 8'h61;
      end
      CS_UPPER: begin
        v_c = is_up;
        d_c = ch - 8'h41;
      end
      CS_ALPHA, CS_ALNUM: begin
        // upper starts at 26, digits at 52
        unique case (1'b1)
          is_lo: begin
            v_c = 1'b1;
            d_c = ch - 8'h61;
          end
          is_up: begin
            v_c = 1'b1;
            d_c = ch - 8'h27;
          end
          is_num: begin
            v_c = (charset == CS_ALNUM);
            d_c = ch + 8'h04;
          end
          default: ;
        endcase
      end
      CS_PRINT: begin
        v_c = is_prt;
        d_c = ch - 8'h21;
      end
      CS_FULL: begin
        v_c = 1'b1;
        d_c = ch;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    digit <= d_c;
    valid <= v_c;
  end

endmodule

// File: rtl/guess_index_encoder.sv
// Converts a matched ASCII guess back to its keyspace index.
// Ports: clk, reset (async, high), bus (slave side of request/result).
module guess_index_encoder
  import guess_index_encoder_pkg::*;
#(
  parameter int GUESS_BYTES = DEF_GUESS_BYTES,
  parameter int IDX_W = DEF_IDX_W
)(
  input  logic                 clk,
  input  logic                 reset,
  guess_index_encoder_if.slave bus
);

  localparam int GW = 8 * GUESS_BYTES;
  localparam int PW = (GUESS_BYTES > 1) ? $clog2(GUESS_BYTES) : 1;

  state_e           state;
  logic [2:0]       cs_q;
  logic [8:0]       size_q;
  logic [GW-1:0]    guess_q;
  logic [PW-1:0]    ptr;
  logic [IDX_W-1:0] acc;
  logic             lk_vld;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;

  logic             cfg_ok;
  logic [7:0]       gbyte [GUESS_BYTES];
  logic [7:0]       ch;
  logic [7:0]       rom_digit;
  logic             rom_valid;
  logic [IDX_W-1:0] scaled;
  logic [IDX_W-1:0] nxt;
  logic             err_fin;

  assign cfg_ok = (bus.charset <= CS_FULL)
               && (bus.guesslen != 5'd0)
               && (bus.guesslen <= 5'(GUESS_BYTES));

  // char k sits at the top of the bus for k=0
  for (genvar k = 0; k < GUESS_BYTES; k++) begin : g_byte
    assign gbyte[k] = guess_q[GW-1-8*k -: 8];
  end

  assign ch = gbyte[ptr];

  charset_reverse_rom u_rom (
    .clk     (clk),
    .charset (cs_q),
    .ch      (ch),
    .digit   (rom_digit),
    .valid   (rom_valid)
  );

  // full byte charset: multiply by 256 is a plain shift
  assign scaled = (size_q == 9'd256)
                ? {acc[IDX_W-9:0], 8'h00}
                : acc * IDX_W'(size_q);
  assign nxt     = scaled + IDX_W'(rom_digit);
  assign err_fin = err_q | ~rom_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cs_q    <= '0;
      size_q  <= '0;
      guess_q <= '0;
      ptr     <= '0;
      acc     <= '0;
      lk_vld  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          lk_vld <= 1'b0;
          if (bus.start) begin
            cs_q    <= bus.charset;
            size_q  <= cs_size(bus.charset);
            guess_q <= bus.guess;
            acc     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            if (cfg_ok) begin
              err_q <= 1'b0;
              ptr   <= PW'(bus.guesslen - 5'd1);
              state <= S_RUN;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_RUN: begin
          // ROM output trails the issued char by one cycle
          lk_vld <= 1'b1;
          if (lk_vld) begin
            acc <= nxt;
            if (!rom_valid) err_q <= 1'b1;
          end
          if (ptr == '0) state <= S_FLUSH;
          else ptr <= ptr - PW'(1);
        end
        S_FLUSH: begin
          acc    <= nxt;
          err_q  <= err_fin;
          idx_q  <= err_fin ? '0 : nxt;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.index = idx_q;

endmodule

// File: tb/tb_guess_index_encoder.sv
// Self-checking bench for guess_index_encoder.
// Scoreboard of expected index/err/done-cycle, popped on done.
module tb_guess_index_encoder;

  typedef struct {
    logic [127:0] idx;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_done = -100;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  guess_index_encoder_if bus ();

  guess_index_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic int csz(input int cs);
    case (cs)
      0, 1:    return 26;
      2:       return 52;
      3:       return 62;
      4:       return 94;
      default: return 256;
    endcase
  endfunction

  // forward generator: digit -> char
  function automatic logic [7:0] fwd(input int cs, input int d);
    case (cs)
      0: return 8'(97 + d);
      1: return 8'(65 + d);
      2: return (d < 26) ? 8'(97 + d) : 8'(65 + d - 26);
      3: begin
        if (d < 26) return 8'(97 + d);
        if (d < 52) return 8'(65 + d - 26);
        return 8'(48 + d - 52);
      end
      4: return 8'(33 + d);
      default: return 8'(d);
    endcase
  endfunction

  function automatic logic [7:0] badc(input int cs);
    case (cs)
      0: return "A";
      1: return "a";
      2: return "5";
      3: return "!";
      default: return ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h7f;
    endcase
  endfunction

  function automatic logic [127:0] setb(
    input logic [127:0] g, input int k, input logic [7:0] c
  );
    logic [127:0] r;
    r = g;
    r[127-8*k -: 8] = c;
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus.index !== e.idx) begin
          errors++;
          $display("FAIL index: got %h expected %h", bus.index, e.idx);
        end
        checks++;
        if (bus.err !== e.err) begin
          errors++;
          $display("FAIL err: got %b expected %b", bus.err, e.err);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL latency: done at cycle %0d expected %0d", cyc, e.cyc);
        end
      end
      last_done = cyc;
    end
  end

  task automatic push(input logic [127:0] i, input logic e, input int c);
    exp_t x;
    x.idx = i;
    x.err = e;
    x.cyc = c;
    sb.push_back(x);
  endtask

  // waits for IDLE, drives start and returns 1 after the accept edge
  // with start still high
  task automatic issue(
    input int cs, input int len, input logic [127:0] g,
    input logic [127:0] ei, input logic ee
  );
    int n;
    bit legal;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b expected 0", bus.busy);
    end
    legal = (cs <= 5) && (len >= 1) && (len <= 16);
    bus.charset  = 3'(cs);
    bus.guesslen = 5'(len);
    bus.guess    = g;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    push(ei, ee, legal ? cyc + len + 1 : cyc);
  endtask

  task automatic run(
    input int cs, input int len, input logic [127:0] g,
    input logic [127:0] ei, input logic ee
  );
    issue(cs, len, g, ei, ee);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.charset = '0;
    bus.guesslen = '0;
    bus.guess = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", bus.err);
    end
    checks++;
    if (bus.index !== '0) begin
      errors++; $display("FAIL reset_index: got %h expected 0", bus.index);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [127:0] g;
    g = setb(setb(setb('1, 0, "c"), 1, "b"), 2, "a");
    run(0, 3, g, 128'd28, 1'b0);
    g = setb(setb(128'h0, 0, "0"), 1, "a");
    run(3, 2, g, 128'd52, 1'b0);
    g = setb(setb(128'h0, 0, "9"), 1, "9");
    run(3, 2, g, 128'd3843, 1'b0);
    run(5, 16, '1, '1, 1'b0);
    run(5, 16, '0, '0, 1'b0);
    g = setb(setb(128'h0, 0, "~"), 1, "!");
    run(4, 2, g, 128'd93, 1'b0);
    drain();
  endtask

  task automatic test_illegal();
    logic [127:0] g;
    g = setb(setb(setb(setb('0, 0, "a"), 1, "a"), 2, "A"), 3, "a");
    run(0, 4, g, '0, 1'b1);
    run(6, 3, g, '0, 1'b1);
    run(7, 1, g, '0, 1'b1);
    run(0, 0, g, '0, 1'b1);
    run(0, 17, g, '0, 1'b1);
    g = setb(setb(128'h0, 0, 8'h20), 1, "!");
    run(4, 2, g, '0, 1'b1);
    g = setb('0, 0, "b");
    run(0, 1, g, 128'd1, 1'b0);
    drain();
  endtask

  task automatic test_start_during_run();
    logic [127:0] g;
    int bad;
    bad = 0;
    g = setb(setb(setb('0, 0, "B"), 1, "C"), 2, "D");
    issue(1, 3, g, 128'd2081, 1'b0);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      bus.start = (i == 1 || i == 2 || i == 4);
      bus.guess = ~g;
      if (bus.busy !== 1'b1) bad++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_cont: %0d low cycles, expected 0", bad);
    end
    drain();
  endtask

  task automatic test_start_held();
    logic [127:0] g1;
    logic [127:0] g2;
    int n;
    g1 = setb(setb('0, 0, "z"), 1, "b");
    g2 = setb(setb('0, 0, "a"), 1, "c");
    issue(0, 2, g1, 128'd51, 1'b0);
    @(negedge clk);
    bus.guess = g2;
    n = 0;
    while (bus.busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL held_timeout: busy=%b expected 0", bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cyc !== last_done + 2) begin
      errors++;
      $display("FAIL reaccept: cycle %0d expected %0d", cyc, last_done + 2);
    end
    push(128'd52, 1'b0, cyc + 3);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reaccept_busy: got %b expected 1", bus.busy);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [127:0] g;
    g = '0;
    for (int k = 0; k < 8; k++) g = setb(g, k, "a");
    g = setb(g, 7, "Z");
    run(0, 8, g, '0, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL abort_err: got %b expected 0", bus.err);
    end
    checks++;
    if (bus.index !== '0) begin
      errors++; $display("FAIL abort_index: got %h expected 0", bus.index);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    g = setb(setb(128'h0, 0, "9"), 1, "9");
    run(3, 2, g, 128'd3843, 1'b0);
    drain();
  endtask

  task automatic test_random();
    for (int it = 0; it < 1000; it++) begin
      int cs;
      int len;
      int sz;
      int d[16];
      logic [127:0] g;
      logic [127:0] e;
      logic bad;
      cs  = $urandom_range(0, 5);
      len = $urandom_range(1, 16);
      sz  = csz(cs);
      g   = {$urandom, $urandom, $urandom, $urandom};
      e   = '0;
      for (int k = 0; k < len; k++) begin
        d[k] = $urandom_range(0, sz - 1);
        g = setb(g, k, fwd(cs, d[k]));
      end
      for (int k = len - 1; k >= 0; k--) e = e * 128'(sz) + 128'(d[k]);
      bad = (cs != 5) && ($urandom_range(0, 7) == 0);
      if (bad) begin
        g = setb(g, $urandom_range(0, len - 1), badc(cs));
        e = '0;
      end
      run(cs, len, g, e, bad);
    end
    drain();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_start_during_run();
    test_start_held();
    test_reset_mid();
    test_random();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
